// File: rtl/pwm_cfg_pkg.sv
// Shared constants and types for the PWM configuration register bank.
// Define PWM_CFG_LOCK_EN to map the port-1 write lock register at ADDR_LOCK.
package pwm_cfg_pkg;

   localparam int ADDR_W = 7;
   localparam int DATA_W = 8;

   localparam logic [ADDR_W-1:0] ADDR_OUT_LO = 7'h00;
   localparam logic [ADDR_W-1:0] ADDR_OUT_HI = 7'h01;
   localparam logic [ADDR_W-1:0] ADDR_PWM_LO = 7'h02;
   localparam logic [ADDR_W-1:0] ADDR_PWM_HI = 7'h03;
   localparam logic [ADDR_W-1:0] ADDR_DUTY   = 7'h04;
   localparam logic [ADDR_W-1:0] ADDR_RAMP   = 7'h05;
   localparam logic [ADDR_W-1:0] ADDR_LOCK   = 7'h06;

   localparam int RAMP_EN_BIT   = 0;
   localparam int RAMP_WRAP_BIT = 1;

`ifdef PWM_CFG_LOCK_EN
   localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_LOCK;
`else
   localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_RAMP;
`endif

   // Round-robin pointer: names the external port that wins a tie.
   typedef enum logic {
      RR_P0 = 1'b0,
      RR_P1 = 1'b1
   } rr_ptr_t;

   function automatic logic addr_mapped(input logic [ADDR_W-1:0] addr);
      return addr <= ADDR_LAST;
   endfunction

endpackage

// File: rtl/pwm_duty_ramp.sv
// Duty-cycle ramp engine: prescaler, single pending step, and the next duty
// value with saturate-at-0xFF or wrap-to-0x00 behaviour.
module pwm_duty_ramp
   import pwm_cfg_pkg::*;
#(
   parameter int RAMP_DIV = 256,
   parameter int PRESC_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic              wrap,
   input  logic [DATA_W-1:0] duty,
   input  logic              grant,
   output logic              req,
   output logic [DATA_W-1:0] next_duty,
   output logic              suppress
);

   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(RAMP_DIV - 1);

   logic [PRESC_W-1:0] presc;
   logic               pending;
   logic               tc;

   assign tc = (presc == PRESC_LAST);

   // A fresh terminal count wins over a same-cycle grant; pending never counts above one.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         presc   <= '0;
         pending <= 1'b0;
      end else if (!enable) begin
         presc   <= '0;
         pending <= 1'b0;
      end else begin
         presc <= tc ? '0 : presc + PRESC_W'(1);
         if (tc) begin
            pending <= 1'b1;
         end else if (grant) begin
            pending <= 1'b0;
         end
      end
   end

   assign req       = pending;
   assign next_duty = duty + DATA_W'(1);
   assign suppress  = (duty == {DATA_W{1'b1}}) && !wrap;

endmodule

// File: rtl/pwm_cfg_arbiter.sv
// PWM / output-enable configuration bank with a round-robin shared write port.
// Optional build macro PWM_CFG_LOCK_EN adds a lock register gating port-1 writes.
module pwm_cfg_arbiter
   import pwm_cfg_pkg::*;
#(
   parameter int RAMP_DIV = 256,
   parameter int PRESC_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              p0_valid,
   output logic              p0_ready,
   input  logic [ADDR_W-1:0] p0_addr,
   input  logic [DATA_W-1:0] p0_data,
   input  logic              p1_valid,
   output logic              p1_ready,
   input  logic [ADDR_W-1:0] p1_addr,
   input  logic [DATA_W-1:0] p1_data,
   output logic [DATA_W-1:0] en_reg_out_7_0,
   output logic [DATA_W-1:0] en_reg_out_15_8,
   output logic [DATA_W-1:0] en_reg_pwm_7_0,
   output logic [DATA_W-1:0] en_reg_pwm_15_8,
   output logic [DATA_W-1:0] pwm_duty_cycle,
   output logic [DATA_W-1:0] ramp_ctrl,
   output logic              wr_err
);

   // Handshake: a write transfers on a rising edge with valid && ready; ready is
   // combinational from valid and the pointer, and addr/data are held while stalled.

   rr_ptr_t           rr_state;
   rr_ptr_t           rr_next;
   logic              g0;
   logic              g1;
   logic              ext_grant;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              wr_blocked;
   logic              wr_ok;
   logic              err_next;
   logic              ramp_req;
   logic              ramp_suppress;
   logic              ramp_grant;
   logic              ramp_we;
   logic [DATA_W-1:0] ramp_duty;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rr_state <= RR_P0;
      end else begin
         rr_state <= rr_next;
      end
   end

   always_comb begin
      rr_next = rr_state;
      if (g0) begin
         rr_next = RR_P1;
      end else if (g1) begin
         rr_next = RR_P0;
      end
   end

   always_comb begin
      g0 = p0_valid && (!p1_valid || (rr_state == RR_P0));
      g1 = p1_valid && (!p0_valid || (rr_state == RR_P1));
   end

   assign p0_ready  = g0;
   assign p1_ready  = g1;
   assign ext_grant = g0 || g1;
   assign wr_addr   = g1 ? p1_addr : p0_addr;
   assign wr_data   = g1 ? p1_data : p0_data;

`ifdef PWM_CFG_LOCK_EN
   logic lock;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lock <= 1'b0;
      end else if (wr_ok && (wr_addr == ADDR_LOCK)) begin
         lock <= wr_data[0];
      end
   end

   // The lock register itself stays writable so port 1 can release it.
   assign wr_blocked = g1 && lock && (wr_addr <= ADDR_RAMP);
`else
   assign wr_blocked = 1'b0;
`endif

   assign wr_ok    = ext_grant && addr_mapped(wr_addr) && !wr_blocked;
   assign err_next = ext_grant && !wr_ok;

   // An external duty write consumes the pending step so it is dropped, not deferred.
   assign ramp_grant = ramp_req && (!ext_grant || (wr_ok && (wr_addr == ADDR_DUTY)));
   assign ramp_we    = ramp_req && !ext_grant && !ramp_suppress;

   pwm_duty_ramp #(
      .RAMP_DIV (RAMP_DIV),
      .PRESC_W  (PRESC_W)
   ) u_ramp (
      .clk       (clk),
      .rst       (rst),
      .enable    (ramp_ctrl[RAMP_EN_BIT]),
      .wrap      (ramp_ctrl[RAMP_WRAP_BIT]),
      .duty      (pwm_duty_cycle),
      .grant     (ramp_grant),
      .req       (ramp_req),
      .next_duty (ramp_duty),
      .suppress  (ramp_suppress)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         en_reg_out_7_0  <= '0;
         en_reg_out_15_8 <= '0;
         en_reg_pwm_7_0  <= '0;
         en_reg_pwm_15_8 <= '0;
         pwm_duty_cycle  <= '0;
         ramp_ctrl       <= '0;
         wr_err          <= 1'b0;
      end else begin
         wr_err <= err_next;
         if (wr_ok) begin
            case (wr_addr)
               ADDR_OUT_LO: en_reg_out_7_0  <= wr_data;
               ADDR_OUT_HI: en_reg_out_15_8 <= wr_data;
               ADDR_PWM_LO: en_reg_pwm_7_0  <= wr_data;
               ADDR_PWM_HI: en_reg_pwm_15_8 <= wr_data;
               ADDR_DUTY:   pwm_duty_cycle  <= wr_data;
               ADDR_RAMP:   ramp_ctrl       <= wr_data;
               default:     ;
            endcase
         end else if (ramp_we) begin
            pwm_duty_cycle <= ramp_duty;
         end
      end
   end

endmodule

// File: tb/tb_pwm_cfg_arbiter.sv
// Bench for pwm_cfg_arbiter: register-bank model checked every cycle plus
// directed literal checks; honours PWM_CFG_LOCK_EN when defined.
module tb_pwm_cfg_arbiter;
   import pwm_cfg_pkg::*;

   localparam int RAMP_DIV = 4;
`ifdef PWM_CFG_LOCK_EN
   localparam int N_REG = 7;
`else
   localparam int N_REG = 6;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       p0_valid = 1'b0;
   logic [6:0] p0_addr = '0;
   logic [7:0] p0_data = '0;
   logic       p1_valid = 1'b0;
   logic [6:0] p1_addr = '0;
   logic [7:0] p1_data = '0;
   logic       p0_ready;
   logic       p1_ready;
   logic [7:0] en_reg_out_7_0;
   logic [7:0] en_reg_out_15_8;
   logic [7:0] en_reg_pwm_7_0;
   logic [7:0] en_reg_pwm_15_8;
   logic [7:0] pwm_duty_cycle;
   logic [7:0] ramp_ctrl;
   logic       wr_err;

   int   checks = 0;
   int   errors = 0;
   logic cmp_en = 1'b0;

   always #5 clk = ~clk;

   pwm_cfg_arbiter #(
      .RAMP_DIV (RAMP_DIV),
      .PRESC_W  (16)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .p0_valid        (p0_valid),
      .p0_ready        (p0_ready),
      .p0_addr         (p0_addr),
      .p0_data         (p0_data),
      .p1_valid        (p1_valid),
      .p1_ready        (p1_ready),
      .p1_addr         (p1_addr),
      .p1_data         (p1_data),
      .en_reg_out_7_0  (en_reg_out_7_0),
      .en_reg_out_15_8 (en_reg_out_15_8),
      .en_reg_pwm_7_0  (en_reg_pwm_7_0),
      .en_reg_pwm_15_8 (en_reg_pwm_15_8),
      .pwm_duty_cycle  (pwm_duty_cycle),
      .ramp_ctrl       (ramp_ctrl),
      .wr_err          (wr_err)
   );

   // Model: register array, tie-break owner, and ramp age counted in enabled cycles.
   logic [7:0] m_reg [0:7];
   logic       m_ptr;
   logic       m_err;
   logic       m_pend;
   int         m_age;
   logic       m_g0, m_g1, m_any, m_wr, m_en, m_tick, m_consume, m_step;
   logic [6:0] m_a;
   logic [7:0] m_d;

   always_comb begin
      m_g0      = p0_valid && (!p1_valid || !m_ptr);
      m_g1      = p1_valid && !m_g0;
      m_any     = m_g0 || m_g1;
      m_a       = m_g0 ? p0_addr : p1_addr;
      m_d       = m_g0 ? p0_data : p1_data;
      m_wr      = m_any && (int'(m_a) < N_REG);
`ifdef PWM_CFG_LOCK_EN
      if (m_g1 && m_reg[6][0] && (int'(m_a) < 6)) m_wr = 1'b0;
`endif
      m_en      = m_reg[5][0];
      m_tick    = m_en && (((m_age + 1) % RAMP_DIV) == 0);
      m_consume = m_pend && (!m_any || (m_wr && (m_a == 7'h04)));
      m_step    = m_pend && !m_any && !((m_reg[4] == 8'hFF) && !m_reg[5][1]);
   end

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 8; i++) m_reg[i] <= 8'h00;
         m_ptr  <= 1'b0;
         m_err  <= 1'b0;
         m_pend <= 1'b0;
         m_age  <= 0;
      end else begin
         m_err <= m_any && !m_wr;
         if (m_g0) m_ptr <= 1'b1;
         else if (m_g1) m_ptr <= 1'b0;
         if (m_wr) m_reg[m_a[2:0]] <= m_d;
         else if (m_step) m_reg[4] <= m_reg[4] + 8'h01;
         if (!m_en) begin
            m_age  <= 0;
            m_pend <= 1'b0;
         end else begin
            m_age  <= m_age + 1;
            m_pend <= m_tick || (m_pend && !m_consume);
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare_loop();
      forever begin
         @(negedge clk);
         if (cmp_en) begin
            check("m_out_lo",  en_reg_out_7_0,  m_reg[0]);
            check("m_out_hi",  en_reg_out_15_8, m_reg[1]);
            check("m_pwm_lo",  en_reg_pwm_7_0,  m_reg[2]);
            check("m_pwm_hi",  en_reg_pwm_15_8, m_reg[3]);
            check("m_duty",    pwm_duty_cycle,  m_reg[4]);
            check("m_ramp",    ramp_ctrl,       m_reg[5]);
            check("m_wr_err",  wr_err,          m_err);
            check("m_p0_rdy",  p0_ready,        m_g0);
            check("m_p1_rdy",  p1_ready,        m_g1);
         end
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // One single-cycle write request from the given port, issued at posedge+1.
   task automatic wr(input int port, input logic [6:0] a, input logic [7:0] d);
      if (port == 0) begin
         p0_valid = 1'b1; p0_addr = a; p0_data = d;
      end else begin
         p1_valid = 1'b1; p1_addr = a; p1_data = d;
      end
      @(posedge clk);
      #1;
      p0_valid = 1'b0;
      p1_valid = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_out_lo"}, en_reg_out_7_0, 8'h00);
      check({tag, "_out_hi"}, en_reg_out_15_8, 8'h00);
      check({tag, "_pwm_lo"}, en_reg_pwm_7_0, 8'h00);
      check({tag, "_pwm_hi"}, en_reg_pwm_15_8, 8'h00);
      check({tag, "_duty"}, pwm_duty_cycle, 8'h00);
      check({tag, "_ramp"}, ramp_ctrl, 8'h00);
      check({tag, "_wr_err"}, wr_err, 1'b0);
   endtask

   initial begin
      fork
         compare_loop();
      join_none

      step(2);
      rst = 1'b1;
      cmp_en = 1'b1;
      @(negedge clk);
      check_all_zero("reset");
      step(1);

      // Single write from port 0.
      p0_valid = 1'b1; p0_addr = 7'h02; p0_data = 8'hA5;
      @(negedge clk);
      check("single_p0_ready", p0_ready, 1'b1);
      check("single_p1_ready", p1_ready, 1'b0);
      @(posedge clk);
      #1;
      p0_valid = 1'b0;
      check("single_pwm_lo", en_reg_pwm_7_0, 8'hA5);

      // Unmapped write from port 1.
      p1_valid = 1'b1; p1_addr = 7'h7F; p1_data = 8'h5A;
      @(negedge clk);
      check("bad_p1_ready", p1_ready, 1'b1);
      @(posedge clk);
      #1;
      p1_valid = 1'b0;
      check("bad_wr_err_hi", wr_err, 1'b1);
      check("bad_pwm_lo_kept", en_reg_pwm_7_0, 8'hA5);
      step(1);
      check("bad_wr_err_lo", wr_err, 1'b0);

      // Assorted writes; reserved ramp_ctrl bits are stored.
      wr(1, 7'h00, 8'h3C);
      wr(0, 7'h03, 8'h5A);
      wr(0, 7'h05, 8'hFC);
      check("ramp_reserved", ramp_ctrl, 8'hFC);
      check("out_lo_3c", en_reg_out_7_0, 8'h3C);
      wr(0, 7'h05, 8'h00);
      wr(1, 7'h01, 8'hC3);

      // Contention: both ports hold valid for four cycles.
      p0_valid = 1'b1; p0_addr = 7'h04; p0_data = 8'h11;
      p1_valid = 1'b1; p1_addr = 7'h04; p1_data = 8'h22;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("rr_p0_ready", p0_ready, (i % 2) == 0);
         check("rr_p1_ready", p1_ready, (i % 2) == 1);
         @(posedge clk);
         #1;
         check("rr_duty", pwm_duty_cycle, ((i % 2) == 0) ? 8'h11 : 8'h22);
      end
      p0_valid = 1'b0;
      p1_valid = 1'b0;

      // Ramp saturate then wrap.
      wr(0, 7'h04, 8'hFD);
      wr(0, 7'h05, 8'h01);
      step(RAMP_DIV + 1);
      check("ramp_fe", pwm_duty_cycle, 8'hFE);
      step(RAMP_DIV);
      check("ramp_ff", pwm_duty_cycle, 8'hFF);
      step(RAMP_DIV);
      check("ramp_hold_ff", pwm_duty_cycle, 8'hFF);
      wr(0, 7'h05, 8'h03);
      step(3);
      check("ramp_wrap_00", pwm_duty_cycle, 8'h00);

      // Collision: pending step coincides with an external duty write.
      step(3);
      wr(0, 7'h04, 8'h40);
      check("coll_duty_40", pwm_duty_cycle, 8'h40);
      step(3);
      check("coll_no_extra", pwm_duty_cycle, 8'h40);
      step(1);
      check("coll_next_step", pwm_duty_cycle, 8'h41);

      // Address 0x06 from port 0.
      wr(0, 7'h06, 8'h00);
`ifdef PWM_CFG_LOCK_EN
      check("addr06_lock_ok", wr_err, 1'b0);
`else
      check("addr06_unmapped", wr_err, 1'b1);
`endif

`ifdef PWM_CFG_LOCK_EN
      wr(1, 7'h06, 8'h01);
      wr(1, 7'h00, 8'hFF);
      check("lock_p1_dropped", en_reg_out_7_0, 8'h3C);
      check("lock_p1_err", wr_err, 1'b1);
      wr(0, 7'h00, 8'hFF);
      check("lock_p0_ok", en_reg_out_7_0, 8'hFF);
      check("lock_p0_no_err", wr_err, 1'b0);
      wr(1, 7'h06, 8'h00);
      wr(1, 7'h01, 8'h77);
      check("unlock_p1_ok", en_reg_out_15_8, 8'h77);
`endif

      // Asynchronous reset in the middle of an active ramp.
      step(2);
      #3;
      rst = 1'b0;
      #1;
      check_all_zero("async_rst");
      @(negedge clk);
      #2;
      rst = 1'b1;
      step(RAMP_DIV + 2);
      check("post_rst_duty", pwm_duty_cycle, 8'h00);
      check("post_rst_ramp", ramp_ctrl, 8'h00);

      // Pointer comes out of reset favouring port 0.
      p0_valid = 1'b1; p0_addr = 7'h01; p0_data = 8'h0F;
      p1_valid = 1'b1; p1_addr = 7'h01; p1_data = 8'hF0;
      @(negedge clk);
      check("rst_ptr_p0", p0_ready, 1'b1);
      check("rst_ptr_p1", p1_ready, 1'b0);
      @(posedge clk);
      #1;
      p0_valid = 1'b0;
      p1_valid = 1'b0;
      check("rst_ptr_data", en_reg_out_15_8, 8'h0F);
      step(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
